// File: rtl/debounce_pkg.sv
// debounce_pkg: shared helpers and types for the debounce_bank block.
//   cnt_width()  - counter width for a cycle count, clog2 with a floor of 1
//   ch_event_t   - per-channel event bundle {level, press, rel, long_press}
package debounce_pkg;

    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

    // "release" is a SystemVerilog keyword, so the release strobe is named rel.
    typedef struct packed {
        logic level;
        logic press;
        logic rel;
        logic long_press;
    } ch_event_t;

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one debounced input.
// Two-flop synchroniser, debounce counter, press/release strobes and, when
// DEBOUNCE_LONG_PRESS_EN is defined, a saturating hold counter with a
// one-shot long-press strobe.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   din         - raw input, already polarity-corrected (1 = pressed)
//   ev          - registered {level, press, rel, long_press}
//   level_next  - next-state of ev.level (lets the parent register an
//                 aggregate that lines up with level)
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int LONG_PRESS_CYCLES = 50000000
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      din,
    output ch_event_t ev,
    output logic      level_next
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_dc_check
        $error("DEBOUNCE_CYCLES must be >= 1");
    end
    if (LONG_PRESS_CYCLES < 1) begin : g_lp_check
        $error("LONG_PRESS_CYCLES must be >= 1");
    end

    logic             sync1, sync2;
    logic             level, press, rel, lp;
    logic [CNT_W-1:0] cnt;
    logic             flip;

    // Accept the new level once it has disagreed with level for
    // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    assign flip       = (sync2 != level) && (cnt == CNT_LAST);
    assign level_next = flip ? sync2 : level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if ((sync2 != level) && !flip) cnt <= cnt + 1'b1;
            else                           cnt <= '0;
            level <= level_next;
            press <= flip &  sync2;
            rel   <= flip & ~sync2;
        end
    end

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);

    logic [HOLD_W-1:0] hold;

    // Saturation makes the strobe one-shot per press; release rearms it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold <= '0;
            lp   <= 1'b0;
        end else begin
            lp <= level && (hold == HOLD_MAX - 1'b1);
            if (!level)                hold <= '0;
            else if (hold != HOLD_MAX) hold <= hold + 1'b1;
        end
    end
`else
    assign lp = 1'b0;
`endif

    assign ev = '{level: level, press: press, rel: rel, long_press: lp};

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: N_CH independent button debouncers.
// Optional long-press detection is compiled in with DEBOUNCE_LONG_PRESS_EN;
// without it long_press is tied to 0 and no hold counters exist.
// Ports:
//   clk, reset     - clock, asynchronous active-high reset
//   button_in      - raw asynchronous inputs (inverted first if ACTIVE_LOW)
//   button_out     - debounced levels, 1 = pressed
//   press_pulse    - one-cycle strobe on accepted 0->1
//   release_pulse  - one-cycle strobe on accepted 1->0
//   any_pressed    - registered OR of button_out, aligned with button_out
//   long_press     - one-cycle strobe after LONG_PRESS_CYCLES of holding
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int N_CH              = 4,
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int ACTIVE_LOW        = 0,
    parameter int LONG_PRESS_CYCLES = 50000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] button_in,
    output logic [N_CH-1:0] button_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic            any_pressed,
    output logic [N_CH-1:0] long_press
);

    if (N_CH < 1) begin : g_n_check
        $error("N_CH must be >= 1");
    end

    logic [N_CH-1:0] din;
    logic [N_CH-1:0] level_next;
    ch_event_t [N_CH-1:0] ev;

    assign din = (ACTIVE_LOW != 0) ? ~button_in : button_in;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .din       (din[i]),
            .ev        (ev[i]),
            .level_next(level_next[i])
        );

        assign button_out[i]    = ev[i].level;
        assign press_pulse[i]   = ev[i].press;
        assign release_pulse[i] = ev[i].rel;
        assign long_press[i]    = ev[i].long_press;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) any_pressed <= 1'b0;
        else       any_pressed <= |level_next;
    end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
Parametrised multi-channel successor to the single-button debouncer. It takes N raw mechanical inputs, synchronises and debounces each one independently, and produces clean levels plus one-cycle press and release strobes. The block sits between board pins and the control FSMs, replacing per-button debouncer instances. An optional long-press detector is compiled in by macro.

Parameters:
- N_CH, 4, number of independent channels (>=1).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a change (>=1); 1 ms at 50 MHz.
- ACTIVE_LOW, 0, 1 = raw inputs are active-low; each input is inverted before the synchroniser.
- LONG_PRESS_CYCLES, 50000000, cycles button_out must stay high before long_press fires (>=1); used only with the macro.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- button_in  in  N_CH  raw, asynchronous button inputs.
- button_out  out  N_CH  debounced level, 1 = pressed.
- press_pulse  out  N_CH  one-cycle strobe on an accepted 0->1 change.
- release_pulse  out  N_CH  one-cycle strobe on an accepted 1->0 change.
- any_pressed  out  1  OR-reduction of button_out (registered).
- long_press  out  N_CH  one-cycle long-press strobe; constant 0 without the macro.

Behaviour:
- One clock; reset is asynchronous and active-high; clock port clk, reset port reset.
- Reset values:
  - All outputs are 0.
  - Synchroniser flops are 0 after the ACTIVE_LOW inversion.
  - All counters are 0.
- Per channel, the raw input (inverted if ACTIVE_LOW=1) passes through a 2-flop synchroniser sync1 -> sync2.
- Debounce counter width is CNT_W = max(1, $clog2(DEBOUNCE_CYCLES)).
- Each cycle where sync2 != button_out:
  - If counter < DEBOUNCE_CYCLES-1, counter increments.
  - Otherwise counter clears to 0 and button_out <= sync2.
- Each cycle where sync2 == button_out, counter clears to 0. Any bounce restarts the count; partial counts never carry over.
- Latency for a clean step on button_in: button_out changes on the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the new value.
- Glitches shorter than DEBOUNCE_CYCLES cycles at sync2 never reach button_out.
- press_pulse / release_pulse:
  - Registered and asserted in the same cycle button_out takes its new value.
  - High for exactly one cycle.
  - Never both high on one channel in the same cycle.
- any_pressed is registered from the next-state of button_out, so it is cycle-aligned with button_out.
- Channels are fully independent. Simultaneous events on several channels each produce their own strobes in the same cycle.
- Reset asserted mid-count or mid-press clears everything immediately. No release_pulse is generated for a channel that was pressed when reset hit.
- DEBOUNCE_CYCLES=1: button_out follows sync2 with one extra cycle (3 edges total).

Optional Feature:
- Macro: DEBOUNCE_LONG_PRESS_EN.
- Defined:
  - Each channel has a hold counter of width $clog2(LONG_PRESS_CYCLES+1).
  - The hold counter clears while button_out=0 and increments while button_out=1, saturating at LONG_PRESS_CYCLES.
  - long_press pulses for one cycle when the counter transitions to LONG_PRESS_CYCLES. It fires once per press, with no auto-repeat.
  - Release clears the counter; a re-press restarts timing.
  - Reset clears the counter.
- Undefined: long_press is tied to 0, and no hold counters are instantiated.

Decomposition:
- Package debounce_pkg holds:
  - the function for counter width, clog2 with a minimum of 1;
  - a typedef for the per-channel event struct {level, press, release, long_press}.
- One sub-module, debounce_channel, covers the synchroniser, debounce counter, strobes and optional hold counter.
- The top generates N_CH instances, applies the ACTIVE_LOW inversion and registers any_pressed.

Test Plan:
- Use N_CH=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10 unless stated.
- Clean press then release: ch0 steps 0->1 at edge 0.
  - button_out[0]=1 and press_pulse[0]=1 at edge 5 (one cycle); any_pressed=1 at edge 5.
  - Release likewise gives release_pulse[0] 6 edges after the step.
- Bounce rejection: ch0 toggles 1,0,1,0 with 3-cycle periods, then stays 1.
  - No output change during the toggling.
  - button_out rises 6 edges after the final stable 1.
- Simultaneous channels: both channels step at the same edge.
  - press_pulse=2'b11 in the same cycle; ch1 unaffected by ch0 bouncing afterwards.
- Reset mid-operation: assert reset asynchronously at counter=2, and again while button_out=1.
  - All outputs go to 0 immediately, with no strobes.
  - After release of reset, a held input is re-accepted after 6 edges.
- ACTIVE_LOW=1: raw input held at 1 gives no press.
  - A 1->0 step gives press_pulse at edge 5.
- DEBOUNCE_LONG_PRESS_EN defined: hold ch0 pressed.
  - long_press[0] pulses exactly once, 10 cycles after button_out rises.
  - No repeat; release then re-press rearms it.
  - With the macro undefined, long_press stays 0.
